// File: rtl/ifetch_ctrl_if.sv
// Fetch-controller bus bundle: PC register link, imem request/response and decode hand-off.
// master = ifetch_ctrl side, slave = PC register / imem / decode side.
interface ifetch_ctrl_if;
  // Valid/ready: a transfer happens in a cycle where both valid and ready are 1.
  // Valid never waits for ready. The imem response has no ready and is taken whenever valid.
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  modport master (
    input  pc, redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rdata, dec_ready,
    output next_pc, imem_req_valid, imem_addr, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    output pc, redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rdata, dec_ready,
    input  next_pc, imem_req_valid, imem_addr, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// RV32 instruction-fetch controller: in-order imem requests into a tagged ring, popped by decode.
// Optional IFETCH_BUBBLE_CNT_EN adds a free-running decode-bubble counter output.
module ifetch_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  ifetch_ctrl_if.master bus
`ifdef IFETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] r_alloc;
  logic [DEPTH-1:0] r_filled;
  logic [31:0]      r_tag   [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [PW-1:0]    r_alloc_ptr;
  logic [PW-1:0]    r_fill_ptr;
  logic [PW-1:0]    r_head_ptr;
  logic [CW-1:0]    r_drop_cnt;

  logic [CW-1:0]    w_free;
  logic [CW-1:0]    w_unfilled;
  logic [CW:0]      w_owed;
  logic             w_req_valid;
  logic             w_req_hs;
  logic             w_fill;
  logic             w_dec_valid;
  logic             w_pop;
  logic             w_unused_bits;

  always_comb begin
    w_free     = '0;
    w_unfilled = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_free     = w_free + CW'(~r_alloc[i]);
      w_unfilled = w_unfilled + CW'(r_alloc[i] & ~r_filled[i]);
    end
  end

  // Stale responses still owed plus live unfilled entries bound what imem may hold in flight.
  assign w_owed      = {1'b0, r_drop_cnt} + {1'b0, w_unfilled};
  assign w_req_valid = rst & ~bus.redirect & (w_free != '0) & (w_owed < (CW+1)'(DEPTH));
  assign w_req_hs    = w_req_valid & bus.imem_req_ready;
  assign w_fill      = rst & ~bus.redirect & bus.imem_rsp_valid & (r_drop_cnt == '0);
  assign w_dec_valid = rst & ~bus.redirect & r_filled[r_head_ptr];
  assign w_pop       = w_dec_valid & bus.dec_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = {bus.pc[31:2], 2'b00};
  assign bus.dec_valid      = w_dec_valid;
  assign bus.dec_instr      = r_instr[r_head_ptr];
  assign bus.dec_pc         = r_tag[r_head_ptr];
  assign w_unused_bits      = ^{bus.pc[1:0], bus.redirect_pc[1:0]};

  always_comb begin
    bus.next_pc = bus.pc;
    if (bus.redirect)
      bus.next_pc = {bus.redirect_pc[31:2], 2'b00};
    else if (w_req_hs)
      bus.next_pc = bus.pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alloc     <= '0;
      r_filled    <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_drop_cnt  <= '0;
    end else if (bus.redirect) begin
      r_alloc     <= '0;
      r_filled    <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      // A response landing in the redirect cycle pays off one owed slot.
      r_drop_cnt  <= r_drop_cnt + w_unfilled - CW'(bus.imem_rsp_valid);
    end else begin
      if (w_req_hs) begin
        r_alloc[r_alloc_ptr]  <= 1'b1;
        r_filled[r_alloc_ptr] <= 1'b0;
        r_alloc_ptr           <= r_alloc_ptr + 1'b1;
      end
      if (w_fill) begin
        r_filled[r_fill_ptr] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + 1'b1;
      end
      if (bus.imem_rsp_valid && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - CW'(1);
      if (w_pop) begin
        r_alloc[r_head_ptr]  <= 1'b0;
        r_filled[r_head_ptr] <= 1'b0;
        r_head_ptr           <= r_head_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_hs)
      r_tag[r_alloc_ptr] <= bus.pc;
    if (w_fill)
      r_instr[r_fill_ptr] <= bus.imem_rdata;
  end

`ifdef IFETCH_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      bubble_cnt <= '0;
    else if (!w_dec_valid && bus.dec_ready)
      bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus random traffic checked against a
// program-order fetch model (expected decode queue) and an in-order imem model.
module tb_ifetch_ctrl;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_ctrl_if bus();
`ifdef IFETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  ifetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFETCH_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  // PC register: resets to 0, loads next_pc every cycle.
  logic [31:0] pc_q = 32'h0;
  always @(posedge clk) pc_q <= rst ? bus.next_pc : 32'h0;
  assign bus.pc = pc_q;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] pc;
    int          epoch;
    int          due;
  } req_t;

  req_t        imem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch_pc = 32'h0;
  logic [31:0] bub_model = 32'h0;
  int          cyc = 0;
  int          epoch = 0;
  int          last_due = 0;
  int          checks = 0;
  int          errors = 0;
  bit          did_redir = 1'b0;
  bit          dv_seen = 1'b0;
  logic [31:0] first_dv_pc = 32'h0;
  int          first_dv_rel = -1;
  int          rel_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0:   w = 32'h0000_0013;
      32'h4:   w = 32'h0010_0093;
      32'h8:   w = 32'h0020_0113;
      default: w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endcase
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // mode: 0 no redirect, 1 redirect, 2 redirect only when a response and a pop coincide.
  task automatic step(input bit rst_n, input int mode, input logic [31:0] tgt,
                      input bit rq_rdy, input bit dc_rdy, input int lat);
    bit   rsp, redir, er, ev, acc, pop;
    int   cur_infl, due;
    req_t item;
    logic [31:0] exp_np;
    @(posedge clk);
    #1;
    rsp   = rst_n && (imem_q.size() > 0) && (imem_q[0].due <= cyc);
    redir = rst_n && ((mode == 1) || (mode == 2 && rsp && exp_q.size() > 0 && dc_rdy));
    did_redir          = redir;
    rst                = rst_n;
    bus.redirect       = redir;
    bus.redirect_pc    = redir ? tgt : $urandom();
    bus.imem_req_ready = rq_rdy;
    bus.dec_ready      = dc_rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rdata     = rsp ? mem_word(imem_q[0].pc) : $urandom();
    #1;
    cur_infl = 0;
    foreach (imem_q[i]) if (imem_q[i].epoch == epoch) cur_infl++;
    er  = rst_n && !redir && (cur_infl + exp_q.size() < DEPTH) && (imem_q.size() < DEPTH);
    ev  = rst_n && !redir && (exp_q.size() > 0);
    acc = er && rq_rdy;
    pop = ev && dc_rdy;
    exp_np = redir ? {tgt[31:2], 2'b00} : (acc ? pc_q + 32'd4 : pc_q);

    check("imem_req_valid", bus.imem_req_valid, er);
    if (er) check("imem_addr", bus.imem_addr, exp_fetch_pc);
    check("next_pc", bus.next_pc, exp_np);
    check("dec_valid", bus.dec_valid, ev);
    if (ev) begin
      check("dec_pc", bus.dec_pc, exp_q[0]);
      check("dec_instr", bus.dec_instr, mem_word(exp_q[0]));
    end
`ifdef IFETCH_BUBBLE_CNT_EN
    check("bubble_cnt", bubble_cnt, bub_model);
`endif
    if (rst_n && bus.dec_valid === 1'b1 && !dv_seen) begin
      dv_seen      = 1'b1;
      first_dv_pc  = bus.dec_pc;
      first_dv_rel = rel_cyc;
    end

    if (!rst_n) begin
      imem_q.delete();
      exp_q.delete();
      epoch++;
      exp_fetch_pc = 32'h0;
      bub_model    = 32'h0;
      last_due     = cyc;
    end else begin
      if (!ev && dc_rdy) bub_model++;
      if (rsp) item = imem_q.pop_front();
      if (redir) begin
        exp_q.delete();
        epoch++;
        exp_fetch_pc = {tgt[31:2], 2'b00};
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (rsp && item.epoch == epoch) exp_q.push_back(item.pc);
        if (acc) begin
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          item.pc    = exp_fetch_pc;
          item.epoch = epoch;
          item.due   = due;
          imem_q.push_back(item);
          last_due     = due;
          exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
      end
    end
    cyc++;
    rel_cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 32'h0, 1'b1, 1'b1, 1);
    dv_seen = 1'b0;
    rel_cyc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.dec_ready      = 1'b0;

    // Reset values and streaming with 1-cycle imem
    do_reset(3);
    repeat (12) step(1'b1, 0, 32'h0, 1'b1, 1'b1, 1);
    check("first_dec_cycle", first_dv_rel, 2);
    check("first_dec_pc", first_dv_pc, 32'h0);

    // Backpressure: ring fills, PC holds at 0x8
    do_reset(2);
    repeat (5) step(1'b1, 0, 32'h0, 1'b1, 1'b0, 1);
    check("bp_next_pc", bus.next_pc, 32'h8);
    check("bp_req_valid", bus.imem_req_valid, 1'b0);
    repeat (8) step(1'b1, 0, 32'h0, 1'b1, 1'b1, 1);
    check("bp_first_dec_pc", first_dv_pc, 32'h0);

    // Redirect with two outstanding requests at latency 3
    do_reset(2);
    repeat (2) step(1'b1, 0, 32'h0, 1'b1, 1'b1, 3);
    step(1'b1, 1, 32'h103, 1'b1, 1'b1, 3);
    check("redir_next_pc", bus.next_pc, 32'h100);
    check("redir_dec_valid", bus.dec_valid, 1'b0);
    dv_seen = 1'b0;
    repeat (14) step(1'b1, 0, 32'h0, 1'b1, 1'b1, 3);
    check("redir_first_dec_pc", first_dv_pc, 32'h100);

    // Redirect coinciding with a response and a would-be decode handshake
    do_reset(2);
    did_redir = 1'b0;
    for (int i = 0; i < 20 && !did_redir; i++) step(1'b1, 2, 32'h40, 1'b1, 1'b1, 1);
    check("combo_redirect_hit", did_redir, 1'b1);
    check("combo_dec_valid", bus.dec_valid, 1'b0);
    dv_seen = 1'b0;
    repeat (8) step(1'b1, 0, 32'h0, 1'b1, 1'b1, 1);
    check("combo_first_dec_pc", first_dv_pc, 32'h40);

    // PC wrap at the top of the address space
    step(1'b1, 1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1);
    dv_seen = 1'b0;
    repeat (10) step(1'b1, 0, 32'h0, 1'b1, 1'b1, 1);
    check("wrap_first_dec_pc", first_dv_pc, 32'hFFFF_FFFC);

    // Random traffic with occasional redirects and one mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset(1);
      end else begin
        step(1'b1, ($urandom_range(0, 15) == 0) ? 1 : 0, $urandom(),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), $urandom_range(1, 4));
      end
    end

`ifdef IFETCH_BUBBLE_CNT_EN
    // Bubble counter: five empty cycles with decode ready, then reset clears it
    do_reset(2);
    repeat (5) step(1'b1, 0, 32'h0, 1'b0, 1'b1, 1);
    step(1'b1, 0, 32'h0, 1'b0, 1'b0, 1);
    check("bubble_five", bubble_cnt, 32'd5);
    do_reset(1);
    step(1'b1, 0, 32'h0, 1'b0, 1'b1, 1);
    check("bubble_reset", bubble_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
